// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter, 11-bit frame:
//    start(0), 8 data bits LSB first, parity, stop(1).
// Parameters:
//    CLK_FREQ   system clock in MHz
//    UART_BPS   baud rate
//    CHECK_SEL  1 = odd parity, 0 = even parity
// Ports:
//    clk_i       system clock, rising edge
//    rst_i       synchronous active-high reset
//    tx_start_i  transmit request, accepted only when tx_ready_o is high
//    tx_data_i   byte to send, captured on the accept cycle
//    tx_ready_o  transmitter idle, can accept a request
//    tx_busy_o   frame in progress
//    tx_done_o   one-cycle pulse after the stop bit completes
//    uart_txd_o  registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int CLK_FREQ  = 50,
   parameter int UART_BPS  = 9600,
   parameter int CHECK_SEL = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic       tx_busy_o,
   output logic       tx_done_o,
   output logic       uart_txd_o
);

   localparam int          BPS_CNT = CLK_FREQ * 1000000 / UART_BPS;
   localparam logic [15:0] BPS_MAX = 16'(BPS_CNT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        txd_q, txd_d;
   logic        done_q, done_d;
   logic        bit_end;

   assign bit_end = (cnt_q == BPS_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;

      // bit timer free-runs in every non-idle state; its wrap is the bit end
      if (state_q != S_IDLE)
         cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (tx_start_i) begin
               state_d = S_START;
               cnt_d   = 16'd0;
               idx_d   = 3'd0;
               shift_d = tx_data_i;
               par_d   = (CHECK_SEL == 1) ? ~^tx_data_i : ^tx_data_i;
            end
         end
         S_START:  if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  state_d = S_PARITY;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
         S_PARITY: if (bit_end) state_d = S_STOP;
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // line level is decoded from the next state so the register holds the
      // bit value for exactly the cycles the state does
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'd0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign tx_ready_o = (state_q == S_IDLE);
   assign tx_busy_o  = (state_q != S_IDLE);
   assign tx_done_o  = done_q;
   assign uart_txd_o = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed bench for uart_tx with BPS_CNT = 10.
// Two instances: dut1 in odd-parity mode, dut0 in even-parity mode.
// Line sample index j counts the cycles after the accept edge (j=1 is the
// first start-bit cycle); bit b of a frame occupies j = b*10+1 .. b*10+10.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst;
   logic start1, start0;
   logic [7:0] data1, data0;
   logic ready1, busy1, done1, txd1;
   logic ready0, busy0, done0, txd0;

   int tests = 0;
   int fails = 0;

   logic line_a [1:300];
   logic done_a [1:300];
   logic busy_a [1:300];

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .tx_start_i(start1), .tx_data_i(data1),
      .tx_ready_o(ready1), .tx_busy_o(busy1), .tx_done_o(done1), .uart_txd_o(txd1));

   uart_tx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .tx_start_i(start0), .tx_data_i(data0),
      .tx_ready_o(ready0), .tx_busy_o(busy0), .tx_done_o(done0), .uart_txd_o(txd0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [7:0] d);
      if (sel == 1) begin start1 = s; data1 = d; end
      else begin start0 = s; data0 = d; end
   endtask

   // Raise a request on the chosen DUT, let the next edge accept it, then
   // record line/done/busy for len cycles. Optional event: at ev_j drive
   // start=1 with ev_data; at rel_j drop start; at rst_j pulse reset 1 cycle.
   task automatic send(input int sel, input logic [7:0] d, input int len,
                       input int ev_j, input logic [7:0] ev_data,
                       input int rel_j, input int rst_j);
      @(negedge clk);
      chk("ready_before_accept", (sel == 1) ? ready1 : ready0, 1);
      drive(sel, 1'b1, d);
      @(posedge clk);
      for (int j = 1; j <= len; j++) begin
         @(negedge clk);
         line_a[j] = (sel == 1) ? txd1  : txd0;
         done_a[j] = (sel == 1) ? done1 : done0;
         busy_a[j] = (sel == 1) ? busy1 : busy0;
         if (j == ev_j)  drive(sel, 1'b1, ev_data);
         if (j == rel_j) drive(sel, 1'b0, 8'h00);
         if (j == rst_j) rst = 1'b1;
         if (j == rst_j + 1) rst = 1'b0;
      end
   endtask

   function automatic logic [10:0] frame(input int off);
      logic [10:0] f;
      for (int b = 0; b < 11; b++) f[b] = line_a[off + b*10 + 5];
      return f;
   endfunction

   function automatic int ndone(input int lo, input int hi);
      int n = 0;
      for (int j = lo; j <= hi; j++) if (done_a[j] === 1'b1) n++;
      return n;
   endfunction

   function automatic int nlow(input int lo, input int hi);
      int n = 0;
      for (int j = lo; j <= hi; j++) if (line_a[j] !== 1'b1) n++;
      return n;
   endfunction

   initial begin
      int lowlen;
      logic bad_txd, bad_rdy, bad_busy, bad_done;

      rst = 1'b1; start1 = 1'b0; start0 = 1'b0; data1 = 8'h00; data0 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_txd",   txd1,   1);
      chk("rst_ready", ready1, 1);
      chk("rst_busy",  busy1,  0);
      chk("rst_done",  done1,  0);
      rst = 1'b0;

      // idle 50 cycles
      bad_txd = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txd1 !== 1'b1 || txd0 !== 1'b1)     bad_txd  = 1;
         if (ready1 !== 1'b1 || ready0 !== 1'b1) bad_rdy  = 1;
         if (busy1 !== 1'b0 || busy0 !== 1'b0)   bad_busy = 1;
         if (done1 !== 1'b0 || done0 !== 1'b0)   bad_done = 1;
      end
      chk("idle_txd_glitch",  bad_txd,  0);
      chk("idle_ready_glitch", bad_rdy, 0);
      chk("idle_busy_glitch", bad_busy, 0);
      chk("idle_done_glitch", bad_done, 0);

      // odd parity, 0x55 -> P=1
      send(1, 8'h55, 115, 0, 8'h00, 1, 0);
      chk("f55_bits", frame(0), {1'b1, 1'b1, 8'h55, 1'b0});
      lowlen = 0;
      while (lowlen < 20 && line_a[lowlen + 1] === 1'b0) lowlen++;
      chk("f55_start_len", lowlen, 10);
      chk("f55_stop_last", line_a[110], 1);
      chk("f55_busy_last", busy_a[110], 1);
      chk("f55_done_at111", done_a[111], 1);
      chk("f55_done_count", ndone(1, 115), 1);
      chk("f55_busy_done_cycle", busy_a[111], 0);

      // parity cases
      send(1, 8'h01, 115, 0, 8'h00, 1, 0);
      chk("odd_01_bits", frame(0), {1'b1, 1'b0, 8'h01, 1'b0});
      send(0, 8'h01, 115, 0, 8'h00, 1, 0);
      chk("even_01_bits", frame(0), {1'b1, 1'b1, 8'h01, 1'b0});
      chk("even_01_done", ndone(1, 115), 1);
      send(0, 8'h00, 115, 0, 8'h00, 1, 0);
      chk("even_00_bits", frame(0), {1'b1, 1'b0, 8'h00, 1'b0});

      // second request mid-frame ignored
      send(1, 8'hA3, 230, 40, 8'h5C, 41, 0);
      chk("ign_bits", frame(0), {1'b1, 1'b1, 8'hA3, 1'b0});
      chk("ign_done_count", ndone(1, 230), 1);
      chk("ign_line_after", nlow(111, 230), 0);

      // held request: back-to-back frames, data resampled at second accept
      send(1, 8'hF0, 230, 111, 8'h0F, 112, 0);
      chk("b2b_f1_bits", frame(0), {1'b1, 1'b1, 8'hF0, 1'b0});
      chk("b2b_f2_bits", frame(111), {1'b1, 1'b1, 8'h0F, 1'b0});
      chk("b2b_gap_high", line_a[111], 1);
      chk("b2b_f2_start", line_a[112], 0);
      chk("b2b_done1", done_a[111], 1);
      chk("b2b_done2", done_a[222], 1);
      chk("b2b_done_count", ndone(1, 230), 2);

      // reset during data bit 4 aborts the frame
      send(1, 8'hFF, 130, 0, 8'h00, 1, 53);
      chk("abort_pre_low", line_a[53], 1'b1);
      chk("abort_line_high", line_a[54], 1);
      chk("abort_busy", busy_a[54], 0);
      chk("abort_no_done", ndone(1, 130), 0);
      send(1, 8'h3C, 115, 0, 8'h00, 1, 0);
      chk("post_abort_bits", frame(0), {1'b1, 1'b1, 8'h3C, 1'b0});
      chk("post_abort_done", ndone(1, 115), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
